// File: rtl/data_memory_hs_pkg.sv
// data_memory_hs_pkg
// Shared constants and types for the handshaked data memory.
//   WORD_WIDTH       default data/address width in bits
//   DATA_MEM_DEPTH   default number of words
//   DATA_MEM_STRB_W  default number of byte lanes (WORD_WIDTH/8)
//   mem_op_e         request opcode, decoded from req_we
package data_memory_hs_pkg;

  localparam int WORD_WIDTH      = 16;
  localparam int DATA_MEM_DEPTH  = 256;
  localparam int DATA_MEM_STRB_W = WORD_WIDTH / 8;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_e;

endpackage

// File: rtl/data_memory_hs_if.sv
// data_memory_hs_if
// Request and read-response channels of the data memory.
//   req_valid/req_ready   request handshake (fire when both high)
//   req_we                1 = write, 0 = read
//   req_addr              word address (ADDR_W bits)
//   req_wdata/req_wstrb   write data and byte-lane enables
//   resp_valid/resp_ready response handshake
//   resp_rdata/resp_err   read data and out-of-range flag
// Modports: master (MEM stage / loader side), slave (memory side).
interface data_memory_hs_if
  import data_memory_hs_pkg::*;
#(
  parameter int DATA_W = WORD_WIDTH,
  parameter int ADDR_W = WORD_WIDTH
);
  localparam int STRB_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/data_memory_hs_dmem_array.sv
// dmem_array
// Pure DEPTH x DATA_W storage with per-byte-lane write enables and a
// synchronous read port. No reset, so synthesis can map it to block RAM.
//   clk    clock
//   we     write enable (lanes further qualified by wstrb)
//   re     read enable; rdata holds its value while re is low
//   wstrb  byte-lane write enables
//   idx    word index
//   wdata  write data
//   rdata  registered read data
module dmem_array
  import data_memory_hs_pkg::*;
#(
  parameter int DATA_W = WORD_WIDTH,
  parameter int DEPTH  = DATA_MEM_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (wstrb[k]) begin
          mem[idx][k*8 +: 8] <= wdata[k*8 +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_memory_hs.sv
// data_memory_hs
// Single-port synchronous data memory behind a valid/ready request channel
// and a registered, backpressurable read-response channel. One access per
// cycle; read latency is one cycle; a response is held until consumed.
//   clk    clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    data_memory_hs_if slave modport (request + response channels)
// Optional build macro: DMEM_RANGE_CHECK_EN
//   defined   -> addresses >= DEPTH are out of range: writes are dropped,
//                reads return zero data with resp_err set
//   undefined -> upper address bits ignored (aliasing), resp_err always 0
module data_memory_hs
  import data_memory_hs_pkg::*;
#(
  parameter int DATA_W = WORD_WIDTH,
  parameter int DEPTH  = DATA_MEM_DEPTH,
  parameter int ADDR_W = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  data_memory_hs_if.slave  bus
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int STRB_W = DATA_W / 8;

  mem_op_e           op;
  logic [IDX_W-1:0]  idx;
  logic              fire;
  logic              wr_fire;
  logic              rd_fire;
  logic              addr_oor;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic              rdata_zero_q;
  logic [DATA_W-1:0] array_rdata;

  assign op  = mem_op_e'(bus.req_we);
  assign idx = bus.req_addr[IDX_W-1:0];

  assign bus.req_ready = !resp_valid_q || bus.resp_ready;

  // rst_n qualifies fire so a request seen during reset never reaches the array.
  assign fire    = bus.req_valid && bus.req_ready && rst_n;
  assign wr_fire = fire && (op == OP_WRITE) && !addr_oor;
  assign rd_fire = fire && (op == OP_READ);

`ifdef DMEM_RANGE_CHECK_EN
  generate
    if (ADDR_W > IDX_W) begin : g_range
      assign addr_oor = |bus.req_addr[ADDR_W-1:IDX_W];
    end else begin : g_no_range
      assign addr_oor = 1'b0;
    end
  endgenerate
`else
  assign addr_oor = 1'b0;
  generate
    if (ADDR_W > IDX_W) begin : g_alias
      logic unused_upper_addr;
      assign unused_upper_addr = ^bus.req_addr[ADDR_W-1:IDX_W];
    end
  endgenerate
`endif

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .STRB_W (STRB_W)
  ) u_array (
    .clk   (clk),
    .we    (wr_fire),
    .re    (rd_fire),
    .wstrb (bus.req_wstrb),
    .idx   (idx),
    .wdata (bus.req_wdata),
    .rdata (array_rdata)
  );

  // The array's read register has no reset, so rdata_zero_q masks it to 0
  // after reset and for out-of-range reads. Only a read fire reloads the
  // response, which is what keeps it frozen while backpressured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_zero_q <= 1'b1;
    end else if (rd_fire) begin
      resp_valid_q <= 1'b1;
      resp_err_q   <= addr_oor;
      rdata_zero_q <= addr_oor;
    end else if (bus.req_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = rdata_zero_q ? '0 : array_rdata;

endmodule

// File: tb/tb_data_memory_hs.sv
// tb_data_memory_hs
// Self-checking bench for data_memory_hs: a shadow memory model produces
// expected read results, pushed to a scoreboard queue when a read fires and
// popped when the response is observed. Honours DMEM_RANGE_CHECK_EN.
module tb_data_memory_hs;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  data_memory_hs_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  data_memory_hs #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [16:0] sb[$];
  logic [15:0] model [DEPTH];

  function automatic logic addr_is_oor(input logic [15:0] a);
    logic oor;
    oor = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
    oor = (a >= 16'(DEPTH));
`endif
    return oor;
  endfunction

  // {err, data} expected for a read of address a, from the shadow model
  function automatic logic [16:0] exp_read(input logic [15:0] a);
    if (addr_is_oor(a)) return {1'b1, 16'h0000};
    return {1'b0, model[a[7:0]]};
  endfunction

  task automatic drive_idle();
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_wstrb  = '0;
  endtask

  // Fires one write at the next edge (caller guarantees req_ready).
  task automatic send_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] s);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wstrb = s;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    if (!addr_is_oor(a)) begin
      for (int k = 0; k < 2; k++) begin
        if (s[k]) model[a[7:0]][k*8 +: 8] = d[k*8 +: 8];
      end
    end
  endtask

  // Fires one read at the next edge and records its expected result.
  task automatic send_read(input logic [15:0] a);
    sb.push_back(exp_read(a));
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive_idle();
    bus.resp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.resp_valid);
    end
    checks++;
    if (bus.resp_rdata !== 16'h0000) begin
      errors++; $display("[TB] FAIL reset_rdata: got %h expected 0000", bus.resp_rdata);
    end
    checks++;
    if (bus.resp_err !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.resp_err);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [16:0] e;
    for (int i = 0; i < 8; i++) send_write(16'(i), 16'h1000 + 16'(i) * 16'h0111, 2'b11);
    send_write(16'h0005, 16'hBEEF, 2'b11);
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL write_no_resp: got %b expected 0", bus.resp_valid);
    end
    send_read(16'h0005);
    checks++;
    if (bus.resp_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL read_latency: got %b expected 1", bus.resp_valid);
    end
    e = sb.pop_front();
    checks++;
    if (bus.resp_rdata !== e[15:0] || bus.resp_rdata !== 16'hBEEF) begin
      errors++; $display("[TB] FAIL read_beef: got %h expected %h", bus.resp_rdata, e[15:0]);
    end
    checks++;
    if (bus.resp_err !== e[16]) begin
      errors++; $display("[TB] FAIL read_beef_err: got %b expected %b", bus.resp_err, e[16]);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL resp_clear: got %b expected 0", bus.resp_valid);
    end
  endtask

  task automatic test_strobe();
    logic [16:0] e;
    send_write(16'h0005, 16'h1234, 2'b01);
    send_read(16'h0005);
    e = sb.pop_front();
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== e[15:0] || bus.resp_rdata !== 16'hBE34) begin
      errors++; $display("[TB] FAIL strobe_low: got v=%b %h expected %h", bus.resp_valid, bus.resp_rdata, e[15:0]);
    end
    send_write(16'h0005, 16'hFFFF, 2'b00);
    send_read(16'h0005);
    e = sb.pop_front();
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== e[15:0] || bus.resp_rdata !== 16'hBE34) begin
      errors++; $display("[TB] FAIL strobe_zero: got v=%b %h expected %h", bus.resp_valid, bus.resp_rdata, e[15:0]);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [16:0] e;
    drain();
    bus.resp_ready = 1'b0;
    send_read(16'h0005);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 16'h0000;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.req_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL hold_ready c%0d: got %b expected 0", c, bus.req_ready);
      end
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== sb[0][15:0] || bus.resp_rdata !== 16'hBE34) begin
        errors++; $display("[TB] FAIL hold_data c%0d: got v=%b %h expected %h", c, bus.resp_valid, bus.resp_rdata, sb[0][15:0]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus.resp_rdata !== 16'hBE34 || bus.resp_err !== 1'b0) begin
      errors++; $display("[TB] FAIL hold_final: got %h err=%b expected be34 err=0", bus.resp_rdata, bus.resp_err);
    end
    bus.resp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL release_ready: got %b expected 1", bus.req_ready);
    end
    void'(sb.pop_front());
    sb.push_back(exp_read(16'h0000));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== e[15:0] || bus.resp_rdata !== 16'h1000) begin
      errors++; $display("[TB] FAIL release_read: got v=%b %h expected %h", bus.resp_valid, bus.resp_rdata, e[15:0]);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [16:0] e;
    drain();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.req_addr = 16'(i);
      sb.push_back(exp_read(16'(i)));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== e[15:0]) begin
        errors++; $display("[TB] FAIL stream addr %0d: got v=%b %h expected v=1 %h", i, bus.resp_valid, bus.resp_rdata, e[15:0]);
      end
    end
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL stream_end: got %b expected 0", bus.resp_valid);
    end
  endtask

  task automatic test_range();
    logic [16:0] e;
    logic [15:0] want_oor;
    logic        want_err;
    logic [15:0] want_after;
`ifdef DMEM_RANGE_CHECK_EN
    want_oor = 16'h0000; want_err = 1'b1; want_after = 16'hBE34;
`else
    want_oor = 16'hBE34; want_err = 1'b0; want_after = 16'h5555;
`endif
    drain();
    send_read(16'h0105);
    e = sb.pop_front();
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== e[15:0] || bus.resp_rdata !== want_oor) begin
      errors++; $display("[TB] FAIL range_rdata: got v=%b %h expected %h", bus.resp_valid, bus.resp_rdata, e[15:0]);
    end
    checks++;
    if (bus.resp_err !== e[16] || bus.resp_err !== want_err) begin
      errors++; $display("[TB] FAIL range_err: got %b expected %b", bus.resp_err, e[16]);
    end
    send_write(16'h0105, 16'h5555, 2'b11);
    send_read(16'h0005);
    e = sb.pop_front();
    checks++;
    if (bus.resp_rdata !== e[15:0] || bus.resp_rdata !== want_after || bus.resp_err !== 1'b0) begin
      errors++; $display("[TB] FAIL range_write: got %h err=%b expected %h err=0", bus.resp_rdata, bus.resp_err, e[15:0]);
    end
    drain();
  endtask

  task automatic test_reset_hold();
    logic [16:0] e;
    drain();
    bus.resp_ready = 1'b0;
    send_read(16'h0003);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 16'h1333) begin
      errors++; $display("[TB] FAIL pre_reset_hold: got v=%b %h expected v=1 1333", bus.resp_valid, bus.resp_rdata);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 16'h0000 || bus.resp_err !== 1'b0) begin
      errors++; $display("[TB] FAIL async_reset: got v=%b %h err=%b expected v=0 0000 err=0", bus.resp_valid, bus.resp_rdata, bus.resp_err);
    end
    sb.delete();
    // A write presented while reset is held must not land in the array.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 16'h0002;
    bus.req_wdata = 16'hDEAD;
    bus.req_wstrb = 2'b11;
    @(posedge clk); #1;
    drive_idle();
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    send_read(16'h0002);
    e = sb.pop_front();
    checks++;
    if (bus.resp_rdata !== e[15:0] || bus.resp_rdata !== 16'h1222) begin
      errors++; $display("[TB] FAIL write_in_reset: got %h expected %h", bus.resp_rdata, e[15:0]);
    end
    send_read(16'h0005);
    e = sb.pop_front();
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== e[15:0]) begin
      errors++; $display("[TB] FAIL contents_kept: got v=%b %h expected %h", bus.resp_valid, bus.resp_rdata, e[15:0]);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_backpressure();
    test_back_to_back();
    test_range();
    test_reset_hold();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/data_memory_hs.md
Name: data_memory_hs

Overview:
Parametrised successor to the single-cycle CPU's data memory, for the pipelined core's MEM stage and the debug loader.
- Single-port synchronous RAM behind a valid/ready request channel and a registered, backpressurable read-response channel.
- Adds per-byte write strobes, configurable width and depth, and back-to-back accesses at one per cycle.
- The read result is held stable until the consumer takes it.

Parameters:
DATA_W, 16 (`WORD_WIDTH), word width in bits; must be a multiple of 8.
DEPTH, 256 (`DATA_MEM_DEPTH), number of words; power of two, at least 2.
ADDR_W, 16 (`WORD_WIDTH), width of the incoming word address.
IDX_W, $clog2(DEPTH) (derived, localparam), width of the internal array index.
STRB_W, DATA_W/8 (derived, localparam), number of byte lanes.

Ports:
clk  in  1  sole clock; all state changes on the rising edge.
rst_n  in  1  reset; asynchronous assert, active-low.
req_valid  in  1  request present.
req_ready  out  1  request accepted this cycle when req_valid and req_ready are both high.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  word address.
req_wdata  in  DATA_W  write data.
req_wstrb  in  STRB_W  byte-lane write enables; ignored for reads.
resp_valid  out  1  read data available.
resp_ready  in  1  consumer takes the response.
resp_rdata  out  DATA_W  read data.
resp_err  out  1  read address was out of range (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - resp_valid=0, resp_rdata=0, resp_err=0; req_ready reads 1 once reset deasserts.
  - Array contents are not reset.
  - A request presented in a cycle where reset is asserted is not performed.
  - A pending response is discarded.
- Handshake:
  - req_ready = !resp_valid || resp_ready, combinational. No dependency on req_valid.
  - Request fire = req_valid && req_ready.
- Write fire:
  - At the edge, mem[idx] lane k <= req_wdata lane k for each k where req_wstrb[k]=1.
  - Other lanes are unchanged.
  - Writes produce no response; resp_valid is then loaded with 0 unless it was held (see Read fire).
- Read fire:
  - At the edge, resp_rdata <= mem[idx] and resp_valid <= 1.
  - Latency is exactly 1 cycle from fire to resp_valid.
- Response hold:
  - While resp_valid && !resp_ready: resp_rdata and resp_err are frozen, and req_ready=0.
  - When resp_ready=1 and no new read fires, resp_valid clears next cycle.
- Back-to-back operation:
  - Read fire plus resp_ready in the same cycle gives continuous 1 read/cycle throughput.
  - Read immediately after a write to the same address (next cycle) returns the new data. No forwarding is needed because the write completed at the prior edge.
- Index: idx = req_addr[IDX_W-1:0].
- Strobe 0 on a write fire: the write is accepted, with no array change.
- resp_rdata is never X after reset, except when reading never-written locations.

Optional Feature:
DMEM_RANGE_CHECK_EN:
- Defined: a request whose req_addr >= DEPTH is out of range.
  - An out-of-range write is accepted and dropped, with no array change.
  - An out-of-range read fires normally, but returns resp_rdata=0 with resp_err=1.
  - In-range reads return resp_err=0.
- Undefined: upper address bits are ignored, so addresses alias modulo DEPTH, and resp_err is tied 0.

Decomposition:
- defines.vh (shared):
  - WORD_WIDTH and DATA_MEM_DEPTH supply the parameter defaults.
  - Add DATA_MEM_STRB_W = WORD_WIDTH/8.
- Sub-module dmem_array:
  - Pure storage: DEPTH x DATA_W with per-lane write enable and synchronous read.
  - No reset.
  - Kept separate so an FPGA block RAM can be inferred or substituted.
- data_memory_hs holds the handshake, response register, hold logic and range check.

Test Plan:
1. Reset deasserts, then write addr 0x05 data 0xBEEF strb 2'b11, then read 0x05 -> resp_valid 1 cycle after read fire, resp_rdata=0xBEEF, resp_err=0.
2. Write 0x05 data 0x1234 strb 2'b01, then read 0x05 -> 0xBE34 (only the low byte is replaced).
3. Read 0x05 with resp_ready=0 for 3 cycles -> resp_rdata held at 0xBE34, req_ready=0, and a new req_valid is not accepted; raise resp_ready -> next read accepted the same cycle.
4. Stream reads of 0x00..0x07 with resp_ready=1 and req_valid held high -> 8 consecutive resp_valid cycles, data in address order, no bubbles.
5. Out-of-range read of 0x0105 with DEPTH=256:
   - DMEM_RANGE_CHECK_EN defined -> resp_rdata=0, resp_err=1, and a write to 0x0105 leaves mem[0x05] unchanged.
   - Undefined -> returns mem[0x05], resp_err=0.
6. Assert rst_n low mid-hold while resp_valid=1 -> resp_valid and resp_rdata go to 0 immediately (asynchronously); after release, previously written contents are still readable.
